bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//   Iterative (shift-and-add-3) binary-to-BCD converter for the keypad/display datapath.
//   Converts an unsigned binary value (0..9999) into four packed BCD digits.
//   Drives the 16-bit BCD input of the 4-digit multiplexed 7-segment driver.
//   Holds the last result stable between conversions, so the display never shows
//   intermediate values. Optionally blanks leading zeros by emitting digit code 4'hF,
//   which the segment decoder renders as all-off.
// PARAMETERS
//   WIDTH_BIN      14  width of bin_i; legal range 1..16
//   BLANK_LEADING  0   1 = replace leading zero digits with 4'hF; units digit never blanked
// PORTS
//   clk_i    in   1          single system clock; all logic on posedge
//   rst_i    in   1          synchronous, active-high reset
//   bin_i    in   WIDTH_BIN  unsigned binary value; sampled only when a start is accepted
//   start_i  in   1          conversion request; level-sampled each cycle
//   busy_o   out  1          conversion in progress
//   done_o   out  1          one-cycle pulse; bcd_o/ovf_o updated on the same edge
//   ovf_o    out  1          last accepted value exceeded 9999
//   bcd_o    out  16         {thousands, hundreds, tens, units}, one 4-bit digit each
// BEHAVIOUR
//   Reset (rst_i=1 at posedge): state=IDLE, bcd_o=16'h0000, ovf_o=0, busy_o=0, done_o=0.
//     Reset takes priority over every other event, including mid-conversion (aborts the conversion).
//     The bcd_o reset value is 16'h0000 regardless of BLANK_LEADING.
//   FSM states: IDLE, SHIFT, DONE.
//   IDLE: if start_i=1 at edge E0, then
//     - latch bin_i into the shift register;
//     - clear the 16-bit BCD scratch register;
//     - load the iteration counter with WIDTH_BIN;
//     - latch over = (bin_i > 9999);
//     - go to SHIFT; busy_o=1 from E0.
//   SHIFT (one iteration per cycle): for each scratch digit >= 5, add 3; then shift
//     {scratch, shreg} left by 1; decrement the counter.
//     After the WIDTH_BIN-th iteration (edge E0+WIDTH_BIN), go to DONE.
//   DONE: at edge E0+WIDTH_BIN+1, commit the result and return to IDLE:
//     - bcd_o <= over ? 16'hFFFF : blank(scratch);
//     - ovf_o <= over;
//     - done_o=1 for exactly that cycle;
//     - busy_o=0 from the same edge.
//   Latency: bcd_o is valid WIDTH_BIN+1 cycles after the accept edge (15 for the default).
//     Latency is fixed; it does not depend on the value or on overflow.
//   start_i while busy_o=1 is ignored; there is no queueing and no error flag.
//   start_i high during the done_o cycle is accepted (state is IDLE), giving back-to-back
//     conversions every WIDTH_BIN+2 cycles. A held start_i re-converts continuously.
//   bin_i changes after the accept edge have no effect on the conversion in progress.
//   Blanking (BLANK_LEADING=1): scanning from the thousands digit, each zero digit
//     preceded only by zeros becomes 4'hF. The units digit is always kept.
//     Examples: 0 -> 16'hFFF0, 7 -> 16'hFFF7, 1005 -> 16'h1005.
//   Overflow output 16'hFFFF (fully blank display) is produced for both BLANK_LEADING values.
//   bcd_o, ovf_o: change only on a DONE commit or on reset.
//   busy_o, done_o: registered.
// TESTING
//   1. Assert rst_i 2 cycles -> bcd_o=16'h0000, busy_o=0, done_o=0, ovf_o=0.
//   2. bin_i=1234, start_i 1 cycle -> busy_o=1 for 15 cycles; bcd_o=16'h1234;
//      done_o high exactly 1 cycle; ovf_o=0.
//   3. bin_i=9999 -> bcd_o=16'h9999, ovf_o=0.
//      Then bin_i=10000 -> bcd_o=16'hFFFF, ovf_o=1.
//      Then bin_i=0 -> bcd_o=16'h0000, ovf_o=0.
//   4. BLANK_LEADING=1: 7 -> 16'hFFF7; 0 -> 16'hFFF0; 40 -> 16'hFF40; 1005 -> 16'h1005.
//   5. start_i pulsed mid-conversion with a different bin_i -> ignored, first result intact.
//      start_i held high -> done_o pulses every 16 cycles.
//   6. rst_i at cycle 5 of a conversion (bin_i=4321) -> next cycle busy_o=0, bcd_o=0, no done_o.
//      A fresh start with 56 -> bcd_o=16'h0056.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
//   Iterative shift-and-add-3 (double dabble) binary-to-BCD converter.
//   One input bit is consumed per clock; the committed result is held stable
//   between conversions so the 7-segment driver never sees partial digits.
//   Values above 9999 produce an all-blank display code (16'hFFFF) and ovf_o.
module bin_to_bcd_seq #(
  parameter int WIDTH_BIN     = 14,
  parameter bit BLANK_LEADING = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WIDTH_BIN-1:0] bin_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 ovf_o,
  output logic [15:0]          bcd_o
);

  // Iteration counter must be able to hold WIDTH_BIN itself.
  localparam int                CNT_W    = $clog2(WIDTH_BIN + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WIDTH_BIN);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [15:0]       BCD_OVF  = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Add 3 to every BCD digit that is 5 or more, so the following left shift
  // carries correctly into the next decimal digit.
  function automatic logic [15:0] add3_digits(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 4; i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Replace leading zero digits with 4'hF (segment decoder shows all-off).
  // The units digit is never blanked, so zero still displays as "0".
  function automatic logic [15:0] blank_leading(input logic [15:0] d);
    logic [15:0] r;
    logic        lead;
    r    = d;
    lead = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (lead && (d[4*i +: 4] == 4'd0)) begin
        r[4*i +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t               r_state;
  logic [WIDTH_BIN-1:0] r_shreg;
  logic [15:0]          r_scratch;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_over;
  logic [15:0]          r_bcd;
  logic                 r_ovf;
  logic                 r_busy;
  logic                 r_done;

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  state_t               w_state_next;
  logic                 w_accept;
  logic                 w_shift;
  logic                 w_commit;
  logic                 w_busy_next;
  logic                 w_bin_over;
  logic [15:0]          w_scratch_adj;
  logic [15:0]          w_scratch_shift;
  logic [WIDTH_BIN-1:0] w_shreg_shift;
  logic [15:0]          w_result;

  // Next-state decode and per-state datapath strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_shift      = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_accept     = 1'b1;
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == CNT_ONE) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_commit     = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    w_busy_next = (w_state_next != S_IDLE);
  end

  // One double-dabble step plus result formatting.
  always_comb begin
    w_bin_over      = (32'(bin_i) > 32'd9999);
    w_scratch_adj   = add3_digits(r_scratch);
    w_scratch_shift = {w_scratch_adj[14:0], r_shreg[WIDTH_BIN-1]};
    w_shreg_shift   = r_shreg << 1;
    if (r_over) begin
      w_result = BCD_OVF;
    end else if (BLANK_LEADING) begin
      w_result = blank_leading(r_scratch);
    end else begin
      w_result = r_scratch;
    end
  end

  // FSM state register; reset aborts any conversion in progress.
  always_ff @(posedge clk_i) begin
    // NOTE: clocked blocks use non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Conversion datapath: load on accept, shift one bit per SHIFT cycle.
  always_ff @(posedge clk_i) begin
    // NOTE: the scratch registers are reset even though a load always
    // precedes their use; it keeps simulation free of X and costs nothing.
    if (rst_i) begin
      r_shreg   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_over    <= 1'b0;
    end else if (w_accept) begin
      r_shreg   <= bin_i;
      r_scratch <= '0;
      r_cnt     <= CNT_LOAD;
      r_over    <= w_bin_over;
    end else if (w_shift) begin
      r_shreg   <= w_shreg_shift;
      r_scratch <= w_scratch_shift;
      r_cnt     <= r_cnt - CNT_ONE;
    end
  end

  // Visible result: changes only on a DONE commit or on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bcd <= 16'h0000;
      r_ovf <= 1'b0;
    end else if (w_commit) begin
      r_bcd <= w_result;
      r_ovf <= r_over;
    end
  end

  // Registered handshake flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_next;
      r_done <= w_commit;
    end
  end

  assign busy_o = r_busy;
  assign done_o = r_done;
  assign ovf_o  = r_ovf;
  assign bcd_o  = r_bcd;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq
//   Directed bench for bin_to_bcd_seq. Two instances share all inputs: one
//   with plain output and one with leading-zero blanking, so each conversion
//   checks both formats against hand-computed values.
module tb_bin_to_bcd_seq;

  localparam int W = 14;

  logic          clk;
  logic          rst;
  logic [W-1:0]  bin;
  logic          start;
  logic          busy0, done0, ovf0;
  logic          busy1, done1, ovf1;
  logic [15:0]   bcd0, bcd1;

  int n_tests;
  int n_fail;

  bin_to_bcd_seq #(.WIDTH_BIN(W), .BLANK_LEADING(1'b0)) dut_plain (
    .clk_i   (clk),
    .rst_i   (rst),
    .bin_i   (bin),
    .start_i (start),
    .busy_o  (busy0),
    .done_o  (done0),
    .ovf_o   (ovf0),
    .bcd_o   (bcd0)
  );

  bin_to_bcd_seq #(.WIDTH_BIN(W), .BLANK_LEADING(1'b1)) dut_blank (
    .clk_i   (clk),
    .rst_i   (rst),
    .bin_i   (bin),
    .start_i (start),
    .busy_o  (busy1),
    .done_o  (done1),
    .ovf_o   (ovf1),
    .bcd_o   (bcd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_tests++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One full conversion. Optionally pulses start_i with another value
  // mid-conversion, which must be ignored.
  task automatic convert(input string tag, input logic [W-1:0] value,
                         input logic [15:0] exp_plain, input logic [15:0] exp_blank,
                         input logic exp_ovf, input bit disturb);
    int          bad;
    logic [15:0] prev0;
    logic [15:0] prev1;
    prev0 = bcd0;
    prev1 = bcd1;
    bin   = value;
    start = 1'b1;
    tick();                       // accept edge E0
    start = 1'b0;
    bin   = ~value;               // must not affect the conversion
    check({tag, ":busy_at_accept"}, {31'd0, busy0}, 32'd1);
    bad = 0;
    for (int k = 1; k <= W; k++) begin
      tick();                     // E0+k
      if (busy0 !== 1'b1 || busy1 !== 1'b1 || done0 !== 1'b0 ||
          done1 !== 1'b0 || bcd0 !== prev0 || bcd1 !== prev1) begin
        bad++;
      end
      if (disturb && k == 5) begin
        start = 1'b1;
        bin   = W'(42);
      end else if (disturb && k == 6) begin
        start = 1'b0;
      end
    end
    check({tag, ":busy_window_bad_cycles"}, 32'(bad), 32'd0);
    tick();                       // E0+W+1: commit
    check({tag, ":done"},      {31'd0, done0}, 32'd1);
    check({tag, ":busy_end"},  {31'd0, busy0}, 32'd0);
    check({tag, ":bcd_plain"}, {16'd0, bcd0},  {16'd0, exp_plain});
    check({tag, ":bcd_blank"}, {16'd0, bcd1},  {16'd0, exp_blank});
    check({tag, ":ovf_plain"}, {31'd0, ovf0},  {31'd0, exp_ovf});
    check({tag, ":ovf_blank"}, {31'd0, ovf1},  {31'd0, exp_ovf});
    tick();
    check({tag, ":done_one_cycle"}, {31'd0, done0}, 32'd0);
    check({tag, ":bcd_held"},       {16'd0, bcd0},  {16'd0, exp_plain});
  endtask

  initial begin
    int n_done;
    int pulse_t[3];
    int bad;

    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    start   = 1'b0;
    bin     = '0;

    // 1. Reset for two cycles.
    tick();
    tick();
    rst = 1'b0;
    check("reset:bcd_plain", {16'd0, bcd0}, 32'h0000);
    check("reset:bcd_blank", {16'd0, bcd1}, 32'h0000);
    check("reset:busy",      {31'd0, busy0}, 32'd0);
    check("reset:done",      {31'd0, done0}, 32'd0);
    check("reset:ovf",       {31'd0, ovf0},  32'd0);

    // 2-4. Basic conversions, limits and blanking patterns.
    convert("c1234",  W'(1234),  16'h1234, 16'h1234, 1'b0, 1'b0);
    convert("c9999",  W'(9999),  16'h9999, 16'h9999, 1'b0, 1'b0);
    convert("c10000", W'(10000), 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    convert("c0",     W'(0),     16'h0000, 16'hFFF0, 1'b0, 1'b0);
    convert("c7",     W'(7),     16'h0007, 16'hFFF7, 1'b0, 1'b0);
    convert("c40",    W'(40),    16'h0040, 16'hFF40, 1'b0, 1'b0);
    convert("c1005",  W'(1005),  16'h1005, 16'h1005, 1'b0, 1'b0);
    convert("c16383", W'(16383), 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);

    // 5a. start_i pulsed mid-conversion with another value is ignored.
    convert("c2468_disturb", W'(2468), 16'h2468, 16'h2468, 1'b0, 1'b1);

    // 5b. Held start_i: done_o pulses at E0+15, E0+31, E0+47.
    bin   = W'(500);
    start = 1'b1;
    tick();                       // accept edge, t = 0
    n_done = 0;
    for (int t = 1; t <= 50; t++) begin
      tick();
      if (done0 === 1'b1) begin
        if (n_done < 3) pulse_t[n_done] = t;
        n_done++;
      end
    end
    start = 1'b0;
    check("held:pulse_count", 32'(n_done), 32'd3);
    check("held:pulse0_t", 32'(pulse_t[0]), 32'd15);
    check("held:pulse1_t", 32'(pulse_t[1]), 32'd31);
    check("held:pulse2_t", 32'(pulse_t[2]), 32'd47);
    check("held:bcd_plain", {16'd0, bcd0}, 32'h0500);
    check("held:bcd_blank", {16'd0, bcd1}, 32'hF500);
    // Drain the conversion started at t = 48.
    for (int t = 0; t < 20; t++) begin
      tick();
    end
    check("held:drained_busy", {31'd0, busy0}, 32'd0);

    // Leave an overflow result visible so reset has something to clear.
    convert("c12000", W'(12000), 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);

    // 6. Reset at cycle 5 of a conversion aborts it.
    bin   = W'(4321);
    start = 1'b1;
    tick();                       // accept edge E0
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
    end
    rst = 1'b1;
    tick();                       // reset edge E0+5
    rst = 1'b0;
    check("abort:busy",      {31'd0, busy0}, 32'd0);
    check("abort:done",      {31'd0, done0}, 32'd0);
    check("abort:bcd_plain", {16'd0, bcd0},  32'h0000);
    check("abort:bcd_blank", {16'd0, bcd1},  32'h0000);
    check("abort:ovf",       {31'd0, ovf0},  32'd0);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done0 !== 1'b0 || busy0 !== 1'b0 || bcd0 !== 16'h0000) bad++;
    end
    check("abort:quiet_cycles_bad", 32'(bad), 32'd0);

    convert("c56", W'(56), 16'h0056, 16'hFF56, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
